dma_controller: RTL and testbench
=================================

Name: dma_controller

Overview:
- Bus-mastering DMA engine beside the pipelined CPU. It copies a block of words from an external device buffer into data memory over the CPU's data-side memory port (address2/data2/writeM2), which the CPU yields on request.
- It runs the BR/BG bus handshake, drives the begin and end notification lines that the CPU samples as dma_begin_interrupt and Interrupt, and sequences the fixed-latency memory writes.

Parameters:
- WORD_SIZE, 16, width of data and address words.
- MEM_LATENCY, 4, cycles each memory write is held (mem_write high, address/data stable); legal range 1..15.
- LEN_WIDTH, 8, width of the transfer-length field.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  CPU-side command strobe.
- cmd_ready  output  1  engine idle; command accepted when cmd_valid && cmd_ready at posedge.
- cmd_addr  input  WORD_SIZE  destination base address in memory.
- cmd_length  input  LEN_WIDTH  number of words to copy.
- BR  output  1  bus request to CPU.
- BG  input  1  bus grant from CPU.
- dev_addr  output  LEN_WIDTH  word index into device buffer.
- dev_data  input  WORD_SIZE  device word at dev_addr, combinational.
- mem_write  output  1  memory write strobe (to writeM2 mux).
- mem_address  output  WORD_SIZE  memory write address.
- mem_data  output  WORD_SIZE  memory write data; top level drives data2 only while mem_write=1.
- dma_begin_interrupt  output  1  one-cycle pulse at start of transfer.
- Interrupt  output  1  one-cycle pulse on completion.
- busy  output  1  engine not in IDLE.

Behaviour:
Reset:
- Reset=1 at posedge forces state IDLE.
- Output values after reset: cmd_ready=1; BR, mem_write, dma_begin_interrupt, Interrupt and busy =0; mem_address, mem_data and dev_addr =0.
- A reset mid-transfer aborts silently: no Interrupt, BR drops next cycle, and any partially written memory words are left as written.

States: IDLE, REQ, XFER, DONE.

IDLE:
- cmd_ready=1. On accept, latch base=cmd_addr, len=cmd_length, idx=0, lat=0.
- len=0 goes directly to DONE; BR is never raised.
- Otherwise go to REQ.

REQ:
- BR=1.
- Stay while BG=0.
- On BG=1 at posedge, go to XFER. dma_begin_interrupt=1 for exactly the first XFER cycle of the command; a re-grant after a pause does not pulse it again.

XFER:
- BR=1, mem_write=1, mem_address=base+idx (mod 2^WORD_SIZE, so wrap-around is legal), dev_addr=idx.
- mem_data is registered from dev_data on entry to each word and held constant for that word.
- lat counts 0..MEM_LATENCY-1. At lat=MEM_LATENCY-1, increment idx and reset lat.
- If idx+1==len, go to DONE; otherwise start the next word in the following cycle with no gap.
- Each word occupies exactly MEM_LATENCY cycles, so an uninterrupted transfer is len*MEM_LATENCY XFER cycles.

BG withdrawn during XFER:
- The word in flight completes its full MEM_LATENCY cycles.
- The engine then returns to REQ with BR still 1 and idx advanced. It resumes at that idx on re-grant.

DONE:
- One cycle. Interrupt=1, BR=0, mem_write=0. Next state IDLE.
- cmd_ready=1 again from the cycle after DONE.

Other rules:
- cmd_valid while busy is ignored and not queued.
- BG=1 while in IDLE is ignored.
- busy=1 in REQ, XFER and DONE.
- mem_address and mem_data return to 0 whenever mem_write=0.

Latency:
- Accept at posedge t: BR=1 during cycle t+1.
- With BG already high, the first XFER cycle is t+2.

Decomposition:
- Shared package/header with const.v: state encoding localparams (IDLE/REQ/XFER/DONE), default MEM_LATENCY and WORD_SIZE, shared with the memory model and testbench.
- One natural sub-module: dma_beat_counter, holding the lat/idx counters with terminal flags word_done and last_word.
- The FSM, handshake and output registers stay in dma_controller.

Test Plan:
1. Reset, then cmd_addr=0x01F4, cmd_length=12 with BG following BR after 1 cycle → 48 consecutive mem_write cycles, addresses 0x01F4..0x01FF each held 4 cycles, data = device words 0..11. dma_begin_interrupt pulses once and Interrupt pulses once 48 cycles later; BR falls in the Interrupt cycle.
2. cmd_length=0 → no BR and no mem_write; Interrupt pulses on the cycle after accept; cmd_ready high on the following cycle.
3. cmd_addr=0xFFFE, cmd_length=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap-around).
4. BG dropped mid-word 3 of 8 → word 3 completes its 4 cycles, mem_write=0 while BG=0 and BR stays 1. On re-grant, resume at word 4 with no second dma_begin_interrupt. Total 32 write cycles.
5. Reset asserted during word 5 of 10 → next cycle all outputs at reset values, no Interrupt. A new command is accepted normally afterwards.
6. cmd_valid pulsed while busy → ignored; only the first command's 12 words are written, and a single Interrupt is produced.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA engine: state encoding and default sizing.
package dma_controller_pkg;

    localparam int DEFAULT_WORD_SIZE   = 16;
    localparam int DEFAULT_MEM_LATENCY = 4;
    localparam int DEFAULT_LEN_WIDTH   = 8;

    // Width of the per-word latency counter; MEM_LATENCY is limited to 1..15.
    localparam int LAT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dma_beat_counter.sv
// Word index and per-word latency counters for the DMA engine.
// word_done marks the final cycle of the current word; last_word marks the
// final word of the command.
module dma_beat_counter
    import dma_controller_pkg::*;
#(
    parameter int LEN_WIDTH   = DEFAULT_LEN_WIDTH,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] len_in,
    input  logic                 run,
    output logic [LEN_WIDTH-1:0] idx,
    output logic                 word_done,
    output logic                 last_word
);

    logic [LEN_WIDTH-1:0] len_q;
    logic [LAT_WIDTH-1:0] lat_q;
    logic [LEN_WIDTH:0]   idx_plus_one;

    assign idx_plus_one = {1'b0, idx} + {{LEN_WIDTH{1'b0}}, 1'b1};
    assign word_done    = (lat_q == LAT_WIDTH'(MEM_LATENCY - 1));
    assign last_word    = (idx_plus_one == {1'b0, len_q});

    // Latch the length on a new command, then step lat every XFER cycle and idx per word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            len_q <= '0;
            idx   <= '0;
            lat_q <= '0;
        end else if (load) begin
            len_q <= len_in;
            idx   <= '0;
            lat_q <= '0;
        end else if (run) begin
            if (word_done) begin
                lat_q <= '0;
                idx   <= idx + LEN_WIDTH'(1);
            end else begin
                lat_q <= lat_q + LAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/dma_controller.sv
// Bus-mastering DMA engine: copies a block of device words into memory over
// the CPU data port after a BR/BG handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a command, cmd_ready high
//   REQ     | BR raised, waiting for (or re-waiting for) BG
//   XFER    | holding mem_write for each word, MEM_LATENCY cycles per word
//   DONE    | single-cycle completion pulse on Interrupt
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int LEN_WIDTH   = DEFAULT_LEN_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_length,
    output logic                 BR,
    input  logic                 BG,
    output logic [LEN_WIDTH-1:0] dev_addr,
    input  logic [WORD_SIZE-1:0] dev_data,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic                 dma_begin_interrupt,
    output logic                 Interrupt,
    output logic                 busy
);

    dma_state_t           state, state_next;
    logic [WORD_SIZE-1:0] base_q;
    logic [WORD_SIZE-1:0] mem_data_q;
    logic                 begun_q;
    logic                 begin_q;
    logic [LEN_WIDTH-1:0] idx;
    logic                 word_done;
    logic                 last_word;
    logic                 accept;
    logic                 new_word;
    logic                 lookahead;

    assign accept = (state == ST_IDLE) && cmd_valid;

    dma_beat_counter #(
        .LEN_WIDTH   (LEN_WIDTH),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_beat (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (accept),
        .len_in    (cmd_length),
        .run       (state == ST_XFER),
        .idx       (idx),
        .word_done (word_done),
        .last_word (last_word)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a withdrawn grant is only honoured at a word boundary.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_length == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (BG) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (word_done) begin
                    if (last_word) begin
                        state_next = ST_DONE;
                    end else if (!BG) begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The device port presents the next word during the last cycle of the current
    // one so its data can be registered as that next word begins.
    assign lookahead = (state == ST_XFER) && word_done && !last_word;
    assign dev_addr  = lookahead ? idx + LEN_WIDTH'(1) : idx;
    assign new_word  = (state_next == ST_XFER) && ((state != ST_XFER) || word_done);

    // Command base, write data capture and the start-of-transfer pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            base_q     <= '0;
            mem_data_q <= '0;
            begun_q    <= 1'b0;
            begin_q    <= 1'b0;
        end else begin
            if (accept) begin
                base_q <= cmd_addr;
            end
            if (new_word) begin
                mem_data_q <= dev_data;
            end else if (state_next != ST_XFER) begin
                mem_data_q <= '0;
            end
            if (accept) begin
                begun_q <= 1'b0;
            end else if ((state == ST_REQ) && BG) begin
                begun_q <= 1'b1;
            end
            begin_q <= (state == ST_REQ) && BG && !begun_q;
        end
    end

    assign cmd_ready           = (state == ST_IDLE);
    assign busy                = (state != ST_IDLE);
    assign BR                  = (state == ST_REQ) || (state == ST_XFER);
    assign mem_write           = (state == ST_XFER);
    assign mem_address         = mem_write ? base_q + WORD_SIZE'(idx) : '0;
    assign mem_data            = mem_data_q;
    assign dma_begin_interrupt = begin_q;
    assign Interrupt           = (state == ST_DONE);

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller with a combinational device-buffer model.
module tb_dma_controller;

    logic        Clk;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_length;
    logic        BR;
    logic        BG;
    logic [7:0]  dev_addr;
    logic [15:0] dev_data;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        dma_begin_interrupt;
    logic        Interrupt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    dma_controller #(
        .WORD_SIZE   (16),
        .MEM_LATENCY (4),
        .LEN_WIDTH   (8)
    ) dut (
        .Clk                 (Clk),
        .Reset               (Reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_addr            (cmd_addr),
        .cmd_length          (cmd_length),
        .BR                  (BR),
        .BG                  (BG),
        .dev_addr            (dev_addr),
        .dev_data            (dev_data),
        .mem_write           (mem_write),
        .mem_address         (mem_address),
        .mem_data            (mem_data),
        .dma_begin_interrupt (dma_begin_interrupt),
        .Interrupt           (Interrupt),
        .busy                (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] dev_word(input int k);
        return 16'h3C00 + 16'(k * 37);
    endfunction

    assign dev_data = dev_word(int'(dev_addr));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Checks n words starting at word index 'first', one check set per cycle.
    task automatic xfer_words(input logic [15:0] base, input int first, input int n,
                              input bit exp_begin, input int drop_at);
        for (int c = 0; c < n * 4; c++) begin
            int w;
            w = first + c / 4;
            chk("xfer_mem_write", 16'(mem_write), 16'd1);
            chk("xfer_br", 16'(BR), 16'd1);
            chk("xfer_addr", mem_address, base + 16'(w));
            chk("xfer_data", mem_data, dev_word(w));
            chk("xfer_begin", 16'(dma_begin_interrupt), (exp_begin && c == 0) ? 16'd1 : 16'd0);
            chk("xfer_irq", 16'(Interrupt), 16'd0);
            if (c == drop_at) BG = 1'b0;
            tick();
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] l);
        cmd_addr   = a;
        cmd_length = l;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_irq"}, 16'(Interrupt), 16'd1);
        chk({tag, "_br_low"}, 16'(BR), 16'd0);
        chk({tag, "_mw_low"}, 16'(mem_write), 16'd0);
        chk({tag, "_addr_zero"}, mem_address, 16'd0);
        chk({tag, "_data_zero"}, mem_data, 16'd0);
        tick();
        chk({tag, "_ready_after"}, 16'(cmd_ready), 16'd1);
        chk({tag, "_irq_after"}, 16'(Interrupt), 16'd0);
        chk({tag, "_busy_after"}, 16'(busy), 16'd0);
    endtask

    initial begin
        Reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = 16'h0;
        cmd_length = 8'h0;
        BG         = 1'b0;
        tick();
        tick();
        Reset = 1'b0;

        // Reset values
        chk("rst_ready", 16'(cmd_ready), 16'd1);
        chk("rst_br", 16'(BR), 16'd0);
        chk("rst_mw", 16'(mem_write), 16'd0);
        chk("rst_begin", 16'(dma_begin_interrupt), 16'd0);
        chk("rst_irq", 16'(Interrupt), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_addr", mem_address, 16'd0);
        chk("rst_data", mem_data, 16'd0);
        chk("rst_dev_addr", 16'(dev_addr), 16'd0);

        // BG while idle is ignored
        BG = 1'b1;
        tick();
        chk("idle_bg_br", 16'(BR), 16'd0);
        chk("idle_bg_mw", 16'(mem_write), 16'd0);
        BG = 1'b0;

        // 1: 12 words from 0x01F4, BG follows BR by one cycle
        issue(16'h01F4, 8'd12);
        chk("t1_req_br", 16'(BR), 16'd1);
        chk("t1_req_busy", 16'(busy), 16'd1);
        chk("t1_req_ready", 16'(cmd_ready), 16'd0);
        chk("t1_req_mw", 16'(mem_write), 16'd0);
        BG = 1'b1;
        tick();
        xfer_words(16'h01F4, 0, 12, 1'b1, -1);
        check_done("t1_done");
        BG = 1'b0;

        // 2: zero-length command
        issue(16'h1234, 8'd0);
        chk("t2_busy", 16'(busy), 16'd1);
        check_done("t2_done");
        tick();
        chk("t2_idle_br", 16'(BR), 16'd0);

        // 3: address wrap-around, BG already high
        BG = 1'b1;
        issue(16'hFFFE, 8'd4);
        chk("t3_req_br", 16'(BR), 16'd1);
        chk("t3_req_mw", 16'(mem_write), 16'd0);
        tick();
        xfer_words(16'hFFFE, 0, 4, 1'b1, -1);
        check_done("t3_done");

        // 4: grant withdrawn during word 3 of 8
        issue(16'h0100, 8'd8);
        tick();
        xfer_words(16'h0100, 0, 4, 1'b1, 13);
        for (int k = 0; k < 3; k++) begin
            chk("t4_pause_mw", 16'(mem_write), 16'd0);
            chk("t4_pause_br", 16'(BR), 16'd1);
            chk("t4_pause_addr", mem_address, 16'd0);
            chk("t4_pause_data", mem_data, 16'd0);
            chk("t4_pause_dev_addr", 16'(dev_addr), 16'd4);
            chk("t4_pause_irq", 16'(Interrupt), 16'd0);
            tick();
        end
        BG = 1'b1;
        tick();
        xfer_words(16'h0100, 4, 4, 1'b0, -1);
        check_done("t4_done");

        // 5: reset during word 5 of 10
        issue(16'h0200, 8'd10);
        tick();
        xfer_words(16'h0200, 0, 5, 1'b1, -1);
        chk("t5_word5_addr", mem_address, 16'h0205);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t5_rst_ready", 16'(cmd_ready), 16'd1);
        chk("t5_rst_br", 16'(BR), 16'd0);
        chk("t5_rst_mw", 16'(mem_write), 16'd0);
        chk("t5_rst_irq", 16'(Interrupt), 16'd0);
        chk("t5_rst_busy", 16'(busy), 16'd0);
        chk("t5_rst_addr", mem_address, 16'd0);
        chk("t5_rst_data", mem_data, 16'd0);
        chk("t5_rst_dev_addr", 16'(dev_addr), 16'd0);
        BG = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_irq", 16'(Interrupt), 16'd0);
        end
        BG = 1'b1;
        issue(16'h0300, 8'd2);
        chk("t5_new_br", 16'(BR), 16'd1);
        tick();
        xfer_words(16'h0300, 0, 2, 1'b1, -1);
        check_done("t5_done");

        // 6: second command while busy is ignored
        issue(16'h0400, 8'd12);
        cmd_addr   = 16'h0800;
        cmd_length = 8'd3;
        cmd_valid  = 1'b1;
        chk("t6_ready_busy", 16'(cmd_ready), 16'd0);
        tick();
        xfer_words(16'h0400, 0, 12, 1'b1, -1);
        cmd_valid = 1'b0;
        check_done("t6_done");
        tick();
        chk("t6_no_queue_busy", 16'(busy), 16'd0);
        chk("t6_no_queue_br", 16'(BR), 16'd0);
        chk("t6_no_queue_irq", 16'(Interrupt), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
